// File: rtl/wb_write_queue.sv
// Write-back queue in front of the regfile write port.
// Merges ALU and load results in order, with forwarding lookup.
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  input  logic [4:0]    alu_reg,
  input  logic [31:0]   alu_data,
  output logic          alu_ready,
  input  logic          ld_valid,
  input  logic [4:0]    ld_reg,
  input  logic [31:0]   ld_data,
  output logic          ld_ready,
  output logic          regWrite,
  output logic [4:0]    writeRegister,
  output logic [31:0]   writeData,
  input  logic [4:0]    fwd_reg,
  output logic          fwd_hit,
  output logic [31:0]   fwd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] TWO_W   = (AW+1)'(2);

  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   free;
  logic [4:0]    reg_q [DEPTH];
  logic [4:0]    reg_d [DEPTH];
  logic [31:0]   dat_q [DEPTH];
  logic [31:0]   dat_d [DEPTH];
  logic          ld_push, alu_push, pop;
  logic [AW-1:0] alu_idx;
  logic [AW-1:0] fwd_idx;

  always_comb begin
    free = DEPTH_W - cnt_q;
    ld_ready = (free != '0);
    // A real load takes a slot first, so the ALU needs a second one.
    if (ld_valid && ld_reg != '0)
      alu_ready = (free >= TWO_W);
    else
      alu_ready = (free != '0);
    ld_push  = ld_valid && ld_ready && ld_reg != '0;
    alu_push = alu_valid && alu_ready && alu_reg != '0;
    pop      = (cnt_q != '0);
    alu_idx  = wr_q + AW'(ld_push);
  end

  always_comb begin
    reg_d = reg_q;
    dat_d = dat_q;
    if (ld_push) begin
      reg_d[wr_q] = ld_reg;
      dat_d[wr_q] = ld_data;
    end
    if (alu_push) begin
      reg_d[alu_idx] = alu_reg;
      dat_d[alu_idx] = alu_data;
    end
    wr_d  = wr_q + AW'(ld_push) + AW'(alu_push);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(ld_push)
          + (AW+1)'(alu_push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    reg_q <= reg_d;
    dat_q <= dat_d;
  end

  always_comb begin
    count = cnt_q;
    empty = (cnt_q == '0);
    full  = (cnt_q == DEPTH_W);
    regWrite      = !empty;
    writeRegister = empty ? '0 : reg_q[rd_q];
    writeData     = empty ? '0 : dat_q[rd_q];
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = rd_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_q + AW'(i);
      if ((AW+1)'(i) < cnt_q && fwd_reg != '0
          && reg_q[fwd_idx] == fwd_reg) begin
        fwd_hit  = 1'b1;
        fwd_data = dat_q[fwd_idx];
      end
    end
  end

endmodule
